axis_pkt_fifo: RTL and testbench
================================

AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 Parameter DATA_W, default 32, meaning tdata width in bits; a multiple of 8, minimum 8.
REQ-002 Parameter DEPTH, default 16, meaning storage entries; a power of 2, minimum 2.
REQ-003 Parameter PKT_MODE, default 0, meaning 0 = cut-through and 1 = store-and-forward on tlast.
REQ-004 Derived constants SHALL be STRB_W = DATA_W/8 and CNT_W = $clog2(DEPTH)+1.
REQ-005 Clock and reset SHALL be: one clock, aclk; reset aresetn is asynchronous and active-low.
REQ-006 Ports SHALL be as follows:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- s_tdata  in  DATA_W  slave data
- s_tstrb  in  STRB_W  slave byte strobes
- s_tlast  in  1  slave end of packet
- s_tvalid  in  1  slave valid
- s_tready  out  1  slave ready
- m_tdata  out  DATA_W  master data
- m_tstrb  out  STRB_W  master strobes
- m_tlast  out  1  master end of packet
- m_tvalid  out  1  master valid
- m_tready  in  1  master ready
- occupancy  out  CNT_W  stored beats
- pkt_count  out  CNT_W  complete packets stored
- overflow_cut  out  1  one-cycle pulse on forced cut-through

Function
REQ-007 A beat SHALL be accepted when s_tvalid && s_tready are high at a rising aclk edge, and emitted when m_tvalid && m_tready are high.
REQ-008 s_tready SHALL equal (occupancy != DEPTH), registered-equivalent, with no combinational path from m_tready.
REQ-009 Storage SHALL be first-word-fall-through: a beat accepted at edge N is presentable on m_* from cycle N+1 onward; there is no same-cycle bypass when empty.
REQ-010 {tdata,tstrb,tlast} SHALL be stored and emitted unmodified, in strict order.
REQ-011 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-012 occupancy: push only +1; pop only -1; push and pop in the same cycle leave it unchanged.
REQ-013 pkt_count: +1 on an accepted beat with s_tlast=1; -1 on an emitted beat with m_tlast=1; both in the same cycle leave it unchanged.
REQ-014 PKT_MODE=0: m_tvalid SHALL be (occupancy != 0).
REQ-015 PKT_MODE=1: m_tvalid SHALL be (occupancy != 0) && (pkt_count != 0 || release_flag).
REQ-016 release_flag SHALL set when occupancy reaches DEPTH with pkt_count==0, and overflow_cut SHALL pulse high for that one cycle.
REQ-017 release_flag SHALL clear on emission of a beat with m_tlast=1.
REQ-018 While m_tvalid=1 and m_tready=0, m_tdata, m_tstrb and m_tlast SHALL hold stable and m_tvalid SHALL stay high.
REQ-019 When full, a push SHALL NOT occur even if a pop happens that cycle; when empty, a pop SHALL NOT occur.
REQ-020 When m_tvalid=0, m_* data outputs are don't-care, and the bench SHALL NOT check them.

Reset
REQ-021 aresetn low SHALL immediately force: pointers 0, occupancy 0, pkt_count 0, release_flag 0, m_tvalid 0, s_tready 0, overflow_cut 0.
REQ-022 s_tready SHALL rise on the first aclk edge after aresetn deasserts.
REQ-023 Reset mid-packet SHALL discard all stored beats, including partial packets; memory contents are not cleared.

Structure
REQ-024 Package axis_pkg SHALL hold the axis_beat_t struct {tdata, tstrb, tlast} and the helper function clog2-based CNT_W derivation.
REQ-025 The sub-module axis_fifo_mem SHALL hold a DEPTH x beat register array (write port plus async read port); control logic stays in axis_pkt_fifo.

Verification
REQ-026 PKT_MODE=0, DEPTH=16: push 0x0..0x3 with m_tready=1 -> the same four words out in order; first m_tvalid one cycle after the first accept.
REQ-027 PKT_MODE=0: push 16 beats with m_tready=0 -> occupancy=16, s_tready=0; then m_tready=1 with s_tvalid=1 -> 16 out, occupancy never exceeds 16.
REQ-028 PKT_MODE=1: push a 3-beat packet, tlast on beat 3 -> m_tvalid stays 0 until the cycle after beat 3 is accepted, then pkt_count=1 and 3 beats emit.
REQ-029 PKT_MODE=1, DEPTH=4: push a 6-beat packet -> overflow_cut pulses once at occupancy=4 and all 6 beats emit in order.
REQ-030 Random m_tready backpressure with continuous push/pop -> m_* stable while stalled, and occupancy and pkt_count match the scoreboard every cycle.
REQ-031 Assert aresetn low with 5 beats stored -> occupancy=0 and m_tvalid=0 immediately; after release the next pushed word is the first one out.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream FIFO types and helpers.
// Holds the default beat layout and the counter-width derivation.
package axis_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_STRB_W = AXIS_DATA_W / 8;

    // One stored beat; the FIFO overrides the width through a type parameter.
    typedef struct packed {
        logic [AXIS_DATA_W-1:0] tdata;
        logic [AXIS_STRB_W-1:0] tstrb;
        logic                   tlast;
    } axis_beat_t;

    // Counter width able to hold the value DEPTH itself.
    function automatic int axis_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Beat storage for axis_pkt_fifo: DEPTH x beat register array.
// Ports: aclk, we/waddr/wdata synchronous write, raddr/rdata async read.
module axis_fifo_mem
    import axis_pkg::*;
#(
    parameter type beat_t = axis_beat_t,
    parameter int  DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  beat_t         wdata,
    input  logic [AW-1:0] raddr,
    output beat_t         rdata
);

    beat_t mem [DEPTH];

    // Contents are deliberately not reset; pointers define validity.
    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with optional store-and-forward on tlast.
// Ports: aclk/aresetn, s_* slave, m_* master, occupancy, pkt_count, overflow_cut.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  DEPTH    = 16,
    parameter int  PKT_MODE = 0,
    localparam int STRB_W   = DATA_W / 8,
    localparam int CNT_W    = axis_cnt_w(DEPTH)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [STRB_W-1:0] s_tstrb,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [STRB_W-1:0] m_tstrb,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [CNT_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              overflow_cut
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [STRB_W-1:0] tstrb;
        logic              tlast;
    } beat_t;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;
    logic [CNT_W-1:0] pkt_q;
    logic [CNT_W-1:0] pkt_d;
    logic             rel_q;
    logic             rel_d;
    logic             rdy_q;

    logic  full;
    logic  empty;
    logic  push;
    logic  pop;
    logic  push_last;
    logic  pop_last;
    logic  rel_set;
    logic  out_valid;
    beat_t wr_beat;
    beat_t rd_beat;

    assign wr_beat = '{tdata: s_tdata, tstrb: s_tstrb, tlast: s_tlast};

    axis_fifo_mem #(
        .beat_t (beat_t),
        .DEPTH  (DEPTH)
    ) u_mem (
        .aclk  (aclk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_beat),
        .raddr (rd_ptr),
        .rdata (rd_beat)
    );

    assign full  = (occ_q == FULL_CNT);
    assign empty = (occ_q == '0);

    // rdy_q tracks !full one edge ahead, so it never depends on m_tready
    // combinationally; it is also low while in reset.
    assign push = s_tvalid && rdy_q && !full;

    // A full buffer holding no complete packet would otherwise deadlock
    // in store-and-forward mode; force it to cut through instead.
    assign rel_set = (PKT_MODE != 0) && full && (pkt_q == '0) && !rel_q;

    always_comb begin
        out_valid = !empty;
        if (PKT_MODE != 0) begin
            out_valid = !empty && ((pkt_q != '0) || rel_q);
        end
    end

    assign pop       = out_valid && m_tready;
    assign push_last = push && s_tlast;
    assign pop_last  = pop && rd_beat.tlast;

    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        pkt_d = pkt_q;
        unique case ({push_last, pop_last})
            2'b10:   pkt_d = pkt_q + 1'b1;
            2'b01:   pkt_d = pkt_q - 1'b1;
            default: pkt_d = pkt_q;
        endcase
    end

    always_comb begin
        rel_d = rel_q;
        unique case (1'b1)
            rel_set:  rel_d = 1'b1;
            pop_last: rel_d = 1'b0;
            default:  rel_d = rel_q;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
            pkt_q  <= '0;
            rel_q  <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ_q <= occ_d;
            pkt_q <= pkt_d;
            rel_q <= rel_d;
            rdy_q <= (occ_d != FULL_CNT);
        end
    end

    assign s_tready     = rdy_q;
    assign m_tvalid     = out_valid;
    assign m_tdata      = rd_beat.tdata;
    assign m_tstrb      = rd_beat.tstrb;
    assign m_tlast      = rd_beat.tlast;
    assign occupancy    = occ_q;
    assign pkt_count    = pkt_q;
    assign overflow_cut = rel_set;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo in cut-through and store-and-forward.
// Three instances: mode 0/DEPTH 16, mode 1/DEPTH 16, mode 1/DEPTH 4.
module tb_axis_pkt_fifo;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic        s_tlast = 1'b0;

    logic        sv [3];
    logic        mr [3];
    logic        srdy [3];
    logic        mv [3];
    logic        ml [3];
    logic        oc [3];
    logic [31:0] md [3];
    logic [3:0]  mk [3];
    logic [4:0]  occ0, occ1, pk0, pk1;
    logic [2:0]  occ2, pk2;
    logic [4:0]  occ_a [3];

    always #5 aclk = ~aclk;

    always_comb begin
        occ_a[0] = occ0;
        occ_a[1] = occ1;
        occ_a[2] = {2'b00, occ2};
    end

    axis_pkt_fifo #(.DATA_W(32), .DEPTH(16), .PKT_MODE(0)) u0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tlast(s_tlast),
        .s_tvalid(sv[0]), .s_tready(srdy[0]),
        .m_tdata(md[0]), .m_tstrb(mk[0]), .m_tlast(ml[0]),
        .m_tvalid(mv[0]), .m_tready(mr[0]),
        .occupancy(occ0), .pkt_count(pk0), .overflow_cut(oc[0])
    );

    axis_pkt_fifo #(.DATA_W(32), .DEPTH(16), .PKT_MODE(1)) u1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tlast(s_tlast),
        .s_tvalid(sv[1]), .s_tready(srdy[1]),
        .m_tdata(md[1]), .m_tstrb(mk[1]), .m_tlast(ml[1]),
        .m_tvalid(mv[1]), .m_tready(mr[1]),
        .occupancy(occ1), .pkt_count(pk1), .overflow_cut(oc[1])
    );

    axis_pkt_fifo #(.DATA_W(32), .DEPTH(4), .PKT_MODE(1)) u2 (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tlast(s_tlast),
        .s_tvalid(sv[2]), .s_tready(srdy[2]),
        .m_tdata(md[2]), .m_tstrb(mk[2]), .m_tlast(ml[2]),
        .m_tvalid(mv[2]), .m_tready(mr[2]),
        .occupancy(occ2), .pkt_count(pk2), .overflow_cut(oc[2])
    );

    int          n_chk = 0;
    int          n_pass = 0;
    logic [36:0] exp_q [$];
    logic [36:0] exp_b;
    logic        pushed, popped, neg_oc, neg_mv;
    logic [36:0] push_beat, pop_beat;
    logic [4:0]  neg_occ;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // One clock: sample handshakes at the falling edge, then cross the
    // rising edge. Accepted beats enter the reference queue.
    task automatic drive_cycle(input int i);
        @(negedge aclk);
        pushed    = sv[i] && srdy[i];
        popped    = mv[i] && mr[i];
        push_beat = {s_tlast, s_tstrb, s_tdata};
        pop_beat  = {ml[i], mk[i], md[i]};
        neg_oc    = oc[i];
        neg_mv    = mv[i];
        neg_occ   = occ_a[i];
        if (pushed) exp_q.push_back(push_beat);
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if (occ0 !== 5'd0) $display("FAIL rst_occ got %0d want 0", occ0);
        else n_pass++;
        n_chk++;
        if (mv[0] !== 1'b0) $display("FAIL rst_mvalid got %b want 0", mv[0]);
        else n_pass++;
        n_chk++;
        if (srdy[0] !== 1'b0) $display("FAIL rst_sready got %b want 0", srdy[0]);
        else n_pass++;
        n_chk++;
        if (oc[2] !== 1'b0) $display("FAIL rst_ocut got %b want 0", oc[2]);
        else n_pass++;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        #1;
        n_chk++;
        if (srdy[0] !== 1'b0) $display("FAIL rel_sready_early got %b want 0", srdy[0]);
        else n_pass++;
        tick();
        n_chk++;
        if (srdy[0] !== 1'b1 || srdy[2] !== 1'b1)
            $display("FAIL rel_sready got %b%b want 11", srdy[0], srdy[2]);
        else n_pass++;
    endtask

    task automatic test_passthrough();
        int idx = 0;
        int nout = 0;
        int first_acc = -1;
        int first_val = -1;
        mr[0] = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            sv[0]   = (idx < 4);
            s_tdata = 32'(idx);
            s_tstrb = 4'hF;
            s_tlast = (idx == 3);
            drive_cycle(0);
            if (neg_mv && first_val < 0) first_val = cyc;
            if (pushed) begin
                if (first_acc < 0) first_acc = cyc;
                idx++;
            end
            if (popped) begin
                n_chk++;
                if (pop_beat !== {(nout == 3), 4'hF, 32'(nout)})
                    $display("FAIL pass_data got %h want %h", pop_beat,
                             {(nout == 3), 4'hF, 32'(nout)});
                else n_pass++;
                exp_b = exp_q.pop_front();
                nout++;
            end
        end
        sv[0] = 1'b0;
        n_chk++;
        if (first_val != first_acc + 1)
            $display("FAIL pass_latency got %0d want %0d", first_val, first_acc + 1);
        else n_pass++;
        n_chk++;
        if (nout != 4) $display("FAIL pass_count got %0d want 4", nout);
        else n_pass++;
    endtask

    task automatic test_full();
        int acc = 0;
        int j = 0;
        int nout = 0;
        int max_occ = 0;
        mr[0] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            sv[0]   = 1'b1;
            s_tdata = 32'h100 + 32'(k);
            s_tstrb = 4'hF;
            s_tlast = (k == 15);
            drive_cycle(0);
            if (pushed) acc++;
        end
        n_chk++;
        if (acc != 16) $display("FAIL full_accepts got %0d want 16", acc);
        else n_pass++;
        n_chk++;
        if (occ0 !== 5'd16) $display("FAIL full_occ got %0d want 16", occ0);
        else n_pass++;
        n_chk++;
        if (srdy[0] !== 1'b0) $display("FAIL full_sready got %b want 0", srdy[0]);
        else n_pass++;
        n_chk++;
        if (pk0 !== 5'd1) $display("FAIL full_pkt got %0d want 1", pk0);
        else n_pass++;
        mr[0] = 1'b1;
        for (int cyc = 0; cyc < 44; cyc++) begin
            sv[0]   = (cyc < 24);
            s_tdata = 32'h200 + 32'(j);
            s_tlast = 1'b0;
            drive_cycle(0);
            if (cyc == 0) begin
                n_chk++;
                if (pushed !== 1'b0) $display("FAIL full_nopush got %b want 0", pushed);
                else n_pass++;
            end
            if (pushed) j++;
            if (popped) begin
                exp_b = (nout < 16) ? {(nout == 15), 4'hF, 32'h100 + 32'(nout)}
                                    : {1'b0, 4'hF, 32'h200 + 32'(nout - 16)};
                n_chk++;
                if (pop_beat !== exp_b)
                    $display("FAIL full_data got %h want %h", pop_beat, exp_b);
                else n_pass++;
                exp_b = exp_q.pop_front();
                nout++;
            end
            if (int'(occ0) > max_occ) max_occ = int'(occ0);
        end
        sv[0] = 1'b0;
        n_chk++;
        if (max_occ > 16) $display("FAIL full_maxocc got %0d want <=16", max_occ);
        else n_pass++;
        n_chk++;
        if (nout != 16 + j) $display("FAIL full_outs got %0d want %0d", nout, 16 + j);
        else n_pass++;
        n_chk++;
        if (occ0 !== 5'd0) $display("FAIL full_drain got %0d want 0", occ0);
        else n_pass++;
    endtask

    task automatic test_store_fwd();
        int idx = 0;
        int nout = 0;
        mr[1] = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            sv[1]   = (idx < 3);
            s_tdata = 32'hA0 + 32'(idx);
            s_tstrb = 4'h3;
            s_tlast = (idx == 2);
            drive_cycle(1);
            if (idx < 3) begin
                n_chk++;
                if (neg_mv !== 1'b0) $display("FAIL sf_early got %b want 0", neg_mv);
                else n_pass++;
            end
            if (pushed) begin
                idx++;
                if (idx == 3) begin
                    n_chk++;
                    if (mv[1] !== 1'b1 || pk1 !== 5'd1)
                        $display("FAIL sf_release got v=%b p=%0d want v=1 p=1", mv[1], pk1);
                    else n_pass++;
                end
            end
            if (popped) begin
                exp_b = {(nout == 2), 4'h3, 32'hA0 + 32'(nout)};
                n_chk++;
                if (pop_beat !== exp_b)
                    $display("FAIL sf_data got %h want %h", pop_beat, exp_b);
                else n_pass++;
                exp_b = exp_q.pop_front();
                nout++;
            end
        end
        sv[1] = 1'b0;
        n_chk++;
        if (nout != 3 || pk1 !== 5'd0 || mv[1] !== 1'b0)
            $display("FAIL sf_end got n=%0d p=%0d v=%b want 3 0 0", nout, pk1, mv[1]);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int idx = 0;
        int nout = 0;
        int pulses = 0;
        int occ_at = 0;
        mr[2] = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            sv[2]   = (idx < 6);
            s_tdata = 32'hB0 + 32'(idx);
            s_tstrb = 4'hF;
            s_tlast = (idx == 5);
            drive_cycle(2);
            if (neg_oc) begin
                pulses++;
                occ_at = int'(neg_occ);
            end
            if (pushed) idx++;
            if (popped) begin
                exp_b = {(nout == 5), 4'hF, 32'hB0 + 32'(nout)};
                n_chk++;
                if (pop_beat !== exp_b)
                    $display("FAIL ovf_data got %h want %h", pop_beat, exp_b);
                else n_pass++;
                exp_b = exp_q.pop_front();
                nout++;
            end
        end
        sv[2] = 1'b0;
        n_chk++;
        if (pulses != 1) $display("FAIL ovf_pulses got %0d want 1", pulses);
        else n_pass++;
        n_chk++;
        if (occ_at != 4) $display("FAIL ovf_occ got %0d want 4", occ_at);
        else n_pass++;
        n_chk++;
        if (nout != 6 || occ2 !== 3'd0)
            $display("FAIL ovf_end got n=%0d occ=%0d want 6 0", nout, occ2);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int          exp_pk = 0;
        logic        prev_stall = 1'b0;
        logic [36:0] prev_beat = '0;
        for (int cyc = 0; cyc < 320; cyc++) begin
            sv[0]   = (cyc < 300) && ($urandom_range(0, 3) != 0);
            s_tdata = $urandom;
            s_tstrb = 4'($urandom_range(0, 15));
            s_tlast = ($urandom_range(0, 3) == 0);
            mr[0]   = (cyc >= 300) || ($urandom_range(0, 1) == 1);
            drive_cycle(0);
            if (prev_stall) begin
                n_chk++;
                if (neg_mv !== 1'b1 || pop_beat !== prev_beat)
                    $display("FAIL bp_stable got v=%b %h want v=1 %h",
                             neg_mv, pop_beat, prev_beat);
                else n_pass++;
            end
            prev_stall = neg_mv && !mr[0];
            prev_beat  = pop_beat;
            if (pushed && push_beat[36]) exp_pk++;
            if (popped) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL bp_underrun got pop want none");
                end else begin
                    exp_b = exp_q.pop_front();
                    if (pop_beat !== exp_b)
                        $display("FAIL bp_data got %h want %h", pop_beat, exp_b);
                    else n_pass++;
                    if (exp_b[36]) exp_pk--;
                end
            end
            n_chk++;
            if (int'(occ0) != exp_q.size())
                $display("FAIL bp_occ got %0d want %0d", occ0, exp_q.size());
            else n_pass++;
            n_chk++;
            if (int'(pk0) != exp_pk)
                $display("FAIL bp_pkt got %0d want %0d", pk0, exp_pk);
            else n_pass++;
        end
        sv[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nout = 0;
        mr[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sv[0]   = 1'b1;
            s_tdata = 32'hC0 + 32'(k);
            s_tstrb = 4'hF;
            s_tlast = 1'b0;
            drive_cycle(0);
        end
        sv[0] = 1'b0;
        n_chk++;
        if (occ0 !== 5'd5) $display("FAIL mid_occ5 got %0d want 5", occ0);
        else n_pass++;
        aresetn = 1'b0;
        #1;
        n_chk++;
        if (occ0 !== 5'd0 || mv[0] !== 1'b0 || srdy[0] !== 1'b0 || pk0 !== 5'd0)
            $display("FAIL mid_async got occ=%0d v=%b r=%b p=%0d want 0 0 0 0",
                     occ0, mv[0], srdy[0], pk0);
        else n_pass++;
        exp_q.delete();
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        n_chk++;
        if (srdy[0] !== 1'b1) $display("FAIL mid_sready got %b want 1", srdy[0]);
        else n_pass++;
        mr[0] = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            sv[0]   = (cyc == 0);
            s_tdata = 32'hCAFE;
            s_tlast = 1'b1;
            drive_cycle(0);
            if (popped) begin
                if (nout == 0) begin
                    n_chk++;
                    if (pop_beat[31:0] !== 32'hCAFE)
                        $display("FAIL mid_first got %h want cafe", pop_beat[31:0]);
                    else n_pass++;
                end
                nout++;
            end
        end
        sv[0] = 1'b0;
        n_chk++;
        if (nout != 1) $display("FAIL mid_count got %0d want 1", nout);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b0;
            mr[i] = 1'b0;
        end
        test_reset();
        test_passthrough();
        test_full();
        test_store_fwd();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
